// File: rtl/cpu_ctrl_pkg.sv
// ============================================================================
// Module      : cpu_ctrl_pkg
// Description : Shared types and encodings for the multi-cycle RV32I sequencer.
//               Holds the FSM state enum, opcode/funct constants and ALU
//               control encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXEC_ALU  = 3'd2,
        EXEC_BR   = 3'd3,
        WRITEBACK = 3'd4,
        TRAP      = 3'd5
    } state_t;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0100000;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;

endpackage

`default_nettype wire

// File: rtl/instr_decode.sv
// ============================================================================
// Module      : instr_decode
// Description : Combinational classification of the registered instruction
//               word into legality, class and ALU/branch attributes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [31:0] i_ir,
    output logic        o_legal,
    output logic        o_is_alu,
    output logic        o_is_branch,
    output logic        o_use_imm,
    output logic [1:0]  o_alu_op,
    output logic        o_br_ne
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    // Register and immediate fields do not affect control.
    logic       w_unused_bits;

    assign w_opcode      = i_ir[6:0];
    assign w_funct3      = i_ir[14:12];
    assign w_funct7      = i_ir[31:25];
    assign w_unused_bits = ^{i_ir[24:15], i_ir[11:7]};

    // Classify the instruction; anything not explicitly matched stays illegal.
    always_comb begin
        o_legal     = 1'b0;
        o_is_alu    = 1'b0;
        o_is_branch = 1'b0;
        o_use_imm   = 1'b0;
        o_alu_op    = ALU_ADD;
        o_br_ne     = 1'b0;
        case (w_opcode)
            OP_IMM: begin
                if (w_funct3 == F3_ADD) begin
                    o_legal   = 1'b1;
                    o_is_alu  = 1'b1;
                    o_use_imm = 1'b1;
                end
            end
            OP_REG: begin
                if (w_funct3 == F3_ADD && w_funct7 == F7_ADD) begin
                    o_legal  = 1'b1;
                    o_is_alu = 1'b1;
                end else if (w_funct3 == F3_ADD && w_funct7 == F7_SUB) begin
                    o_legal  = 1'b1;
                    o_is_alu = 1'b1;
                    o_alu_op = ALU_SUB;
                end
            end
            OP_BRANCH: begin
                if (w_funct3 == F3_BEQ || w_funct3 == F3_BNE) begin
                    o_legal     = 1'b1;
                    o_is_branch = 1'b1;
                    o_br_ne     = (w_funct3 == F3_BNE);
                end
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module      : multicycle_ctrl
// Description : Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer for the
//               RV32I datapath, with instruction-memory fetch handshake,
//               fetch timeout and sticky trap state.
//               Optional macro MULTICYCLE_CTRL_INSTRET_EN enables the 32-bit
//               retired-instruction counter; otherwise instret is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int FETCH_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] instr,
    input  logic                  mem_ready,
    input  logic                  EQ,
    output logic                  PCWrite,
    output logic                  IRWrite,
    output logic                  RegWrite,
    output logic                  ALUsrc,
    output logic [1:0]            ALUctrl,
    output logic                  ImmSrc,
    output logic                  PCsrc,
    output logic                  halt,
    output logic [31:0]           instret
);

    localparam logic [7:0] c_TMO_LAST = 8'(FETCH_TIMEOUT - 1);

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_ir;
    logic [7:0]            r_tmo;

    logic       w_legal;
    logic       w_is_alu;
    logic       w_is_branch;
    logic       w_use_imm;
    logic [1:0] w_alu_op;
    logic       w_br_ne;

    instr_decode u_decode (
        .i_ir        (r_ir[31:0]),
        .o_legal     (w_legal),
        .o_is_alu    (w_is_alu),
        .o_is_branch (w_is_branch),
        .o_use_imm   (w_use_imm),
        .o_alu_op    (w_alu_op),
        .o_br_ne     (w_br_ne)
    );

    // Sequencer state, instruction register and fetch timeout counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FETCH;
            r_ir    <= '0;
            r_tmo   <= 8'd0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (mem_ready) begin
                        r_ir    <= instr;
                        r_tmo   <= 8'd0;
                        r_state <= DECODE;
                    end else begin
                        r_tmo <= r_tmo + 8'd1;
                        if (r_tmo == c_TMO_LAST) begin
                            r_state <= TRAP;
                        end
                    end
                end
                DECODE: begin
                    if (!w_legal) begin
                        r_state <= TRAP;
                    end else if (w_is_alu) begin
                        r_state <= EXEC_ALU;
                    end else if (w_is_branch) begin
                        r_state <= EXEC_BR;
                    end else begin
                        r_state <= TRAP;
                    end
                end
                EXEC_ALU:  r_state <= WRITEBACK;
                EXEC_BR:   r_state <= FETCH;
                WRITEBACK: r_state <= FETCH;
                TRAP:      r_state <= TRAP;
                default:   r_state <= TRAP;
            endcase
        end
    end

    // Datapath strobes from state and IR; EXEC_ALU settings are held through
    // WRITEBACK so the write-back data stays stable.
    always_comb begin
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        RegWrite = 1'b0;
        ALUsrc   = 1'b0;
        ALUctrl  = ALU_ADD;
        ImmSrc   = 1'b0;
        PCsrc    = 1'b0;
        halt     = 1'b0;
        case (r_state)
            FETCH: begin
                IRWrite = mem_ready & ~rst;
            end
            EXEC_ALU: begin
                ALUsrc  = w_use_imm;
                ALUctrl = w_alu_op;
            end
            WRITEBACK: begin
                RegWrite = 1'b1;
                PCWrite  = 1'b1;
                ALUsrc   = w_use_imm;
                ALUctrl  = w_alu_op;
            end
            EXEC_BR: begin
                PCWrite = 1'b1;
                ALUctrl = ALU_SUB;
                ImmSrc  = 1'b1;
                PCsrc   = w_br_ne ? ~EQ : EQ;
            end
            TRAP: begin
                halt = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef MULTICYCLE_CTRL_INSTRET_EN
    logic [31:0] r_instret;

    // Count retiring cycles; TRAP never retires so the count freezes there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instret <= 32'd0;
        end else if (r_state == EXEC_BR || r_state == WRITEBACK) begin
            r_instret <= r_instret + 32'd1;
        end
    end

    assign instret = r_instret;
`else
    assign instret = 32'd0;
`endif

endmodule

`default_nettype wire

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle sequencer for the RV32I datapath (RegFile, ALU, SignExtend, PC_register, next_PC, InstrMem).
- Replaces single-cycle combinational control with an FSM: fetch, decode, execute, writeback.
- Adds a fetch handshake with instruction memory and a halt/trap state for illegal instructions or fetch timeout.
- Drives the datapath strobes directly.

Parameters:
DATA_WIDTH, 32, instruction width
FETCH_TIMEOUT, 16, max cycles waiting for mem_ready in FETCH before trap; legal range 2..255

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
instr  input  DATA_WIDTH  instruction word from InstrMem
mem_ready  input  1  instruction memory has valid data this cycle
EQ  input  1  ALU equality flag
PCWrite  output  1  PC_register load enable
IRWrite  output  1  capture instr into internal IR
RegWrite  output  1  RegFile write enable
ALUsrc  output  1  0 = register operand, 1 = ImmOp
ALUctrl  output  2  00 add, 01 sub, 10/11 reserved (never driven)
ImmSrc  output  1  0 = I-type immediate, 1 = B-type immediate
PCsrc  output  1  0 = PC+4, 1 = PC+ImmOp
halt  output  1  sticky trap indicator
instret  output  32  retired-instruction count (see Optional Feature)

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on rst.
- Reset: state = FETCH, IR = 0, timeout counter = 0, instret = 0. All strobes and halt are 0.
- Strobes are decoded from state and the registered IR only. They do not depend combinationally on instr.
- Supported instructions:
  - addi: opcode 0010011, f3 000
  - add: opcode 0110011, f3 000, f7 0000000
  - sub: opcode 0110011, f3 000, f7 0100000
  - beq: opcode 1100011, f3 000
  - bne: opcode 1100011, f3 001
  - Any other encoding is illegal.
- FETCH:
  - mem_ready=0: all strobes 0; timeout counter increments.
  - Counter reaches FETCH_TIMEOUT-1 with mem_ready still 0: go to TRAP next cycle.
  - mem_ready=1: IRWrite=1, IR <= instr, counter cleared, go to DECODE.
- DECODE:
  - All strobes 0.
  - Illegal IR: go to TRAP.
  - ALU-type: go to EXEC_ALU.
  - Branch: go to EXEC_BR.
- EXEC_ALU:
  - ALUsrc = 1 for addi, 0 for add/sub.
  - ALUctrl = 01 for sub, else 00.
  - ImmSrc = 0.
  - Go to WRITEBACK.
- EXEC_BR:
  - ALUsrc=0, ALUctrl=01, ImmSrc=1, PCWrite=1.
  - PCsrc = EQ for beq, ~EQ for bne.
  - Instruction retires; go to FETCH.
- WRITEBACK:
  - RegWrite=1, PCWrite=1, PCsrc=0.
  - ALUsrc/ALUctrl/ImmSrc are held at their EXEC_ALU values so wd3 is stable.
  - Instruction retires; go to FETCH.
- TRAP: halt=1, all write strobes 0, stays in TRAP until rst.
- Latency with mem_ready=1 on first FETCH cycle: ALU instruction 4 cycles, branch 3 cycles. Each cycle mem_ready is low adds one cycle.
- rd=x0 writes still assert RegWrite; RegFile discards them.
- Reset mid-instruction: the in-flight instruction is abandoned with no partial writes after rst rises. The state returns to FETCH asynchronously.
- mem_ready outside FETCH is ignored.

Optional Feature:
Macro: MULTICYCLE_CTRL_INSTRET_EN
- Defined: 32-bit instret increments by 1 on each retiring cycle (EXEC_BR or WRITEBACK). It wraps 0xFFFFFFFF -> 0, freezes in TRAP, and clears on rst.
- Undefined: the port exists and is tied to 0; no counter flops are inferred.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - state enum: FETCH, DECODE, EXEC_ALU, EXEC_BR, WRITEBACK, TRAP
  - opcode constants: OP_IMM, OP_REG, OP_BRANCH
  - funct3/funct7 constants
  - ALUctrl encodings: ALU_ADD, ALU_SUB
- Sub-module instr_decode: combinational IR -> {legal, is_alu, is_branch, use_imm, alu_op, br_ne}.
- FSM, timeout counter and instret stay in multicycle_ctrl.

Test Plan:
1. rst pulse mid-WRITEBACK, asynchronous to clk -> strobes drop to 0 without waiting for a clock edge; next cycle is FETCH with IRWrite only when mem_ready=1.
2. addi 0x00500093 with mem_ready=1 -> IRWrite@c0, EXEC_ALU@c2 with ALUsrc=1/ALUctrl=00, RegWrite=1/PCWrite=1/PCsrc=0@c3, FETCH@c4.
3. sub 0x40208033 -> ALUctrl=01 and ALUsrc=0 in both EXEC_ALU and WRITEBACK.
4. bne 0xFE209EE3 with EQ=0 -> EXEC_BR@c2 with PCWrite=1, PCsrc=1, ImmSrc=1. Same instruction with EQ=1 -> PCsrc=0.
5. Illegal 0x00000000 -> TRAP after DECODE: halt=1 sticky, no further PCWrite for 50 cycles, cleared only by rst.
6. mem_ready held 0 with FETCH_TIMEOUT=16 -> halt rises on cycle 16. With the macro defined and 3 retired instructions beforehand, instret=3 and stays frozen.
